// File: rtl/gaussian_pkg.sv
// Shared types and constants for the 3x3 Gaussian filter.
// The optional GAUSSIAN_ROUND_EN rounding is selected in gaussian_filter.sv.
package gaussian_pkg;

  typedef enum logic [1:0] {
    PROLOGUE,
    RUN,
    FLUSH
  } state_t;

  localparam int SUM_WIDTH = 12;
  localparam int SUM_SHIFT = 4;

  localparam logic [SUM_WIDTH-1:0] K_CORNER    = 12'd1;
  localparam logic [SUM_WIDTH-1:0] K_EDGE      = 12'd2;
  localparam logic [SUM_WIDTH-1:0] K_CENTRE    = 12'd4;
  localparam logic [SUM_WIDTH-1:0] ROUND_CONST = 12'd8;

  // One kernel row [1 2 1]; the middle row reuses it scaled by K_EDGE.
  function automatic logic [SUM_WIDTH-1:0] tri_sum(
    input logic [SUM_WIDTH-1:0] a,
    input logic [SUM_WIDTH-1:0] b,
    input logic [SUM_WIDTH-1:0] c
  );
    return K_CORNER * a + K_EDGE * b + K_CORNER * c;
  endfunction

endpackage

// File: rtl/gaussian_linebuf.sv
// Enable-gated pixel shift register of parameterized depth (one image line segment).
module gaussian_linebuf
  import gaussian_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DWIDTH = 8
) (
  input  logic              clock,
  input  logic              en,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // No reset and no read port other than the tail: maps onto shift-register primitives.
  always_ff @(posedge clock) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/gaussian_filter.sv
// 3x3 Gaussian filter between two FWFT FIFOs, one output per accepted pixel.
// Define GAUSSIAN_ROUND_EN for round-half-up output; default is truncation.
module gaussian_filter
  import gaussian_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full,
  output logic              out_wr_en
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_t            state_reg, state_next;
  logic              go_reg;
  logic [CW-1:0]     in_col_reg, out_col_reg;
  logic [RW-1:0]     in_row_reg, out_row_reg;

  // Window taps: a* = current line, b* = one line back, c* = two lines back.
  logic [DWIDTH-1:0] a0_reg, a1_reg;
  logic [DWIDTH-1:0] b0_reg, b1_reg, b2_reg;
  logic [DWIDTH-1:0] c0_reg, c1_reg, c2_reg;
  logic [DWIDTH-1:0] lb1_out, lb2_out;

  logic [SUM_WIDTH-1:0] sum, sum_adj;
  logic [DWIDTH-1:0]    filt;
  logic                 out_border, last_in, last_out, prologue_done;

  gaussian_linebuf #(.DEPTH(IMG_WIDTH - 3), .DWIDTH(DWIDTH)) u_lb1 (
    .clock (clock),
    .en    (in_rd_en),
    .din   (a1_reg),
    .dout  (lb1_out)
  );

  gaussian_linebuf #(.DEPTH(IMG_WIDTH - 3), .DWIDTH(DWIDTH)) u_lb2 (
    .clock (clock),
    .en    (in_rd_en),
    .din   (b2_reg),
    .dout  (lb2_out)
  );

  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      a0_reg <= in_dout;
      a1_reg <= a0_reg;
      b0_reg <= lb1_out;
      b1_reg <= b0_reg;
      b2_reg <= b1_reg;
      c0_reg <= lb2_out;
      c1_reg <= c0_reg;
      c2_reg <= c1_reg;
    end
  end

  assign sum = K_CORNER * tri_sum(SUM_WIDTH'(in_dout), SUM_WIDTH'(a0_reg), SUM_WIDTH'(a1_reg))
             + K_EDGE   * tri_sum(SUM_WIDTH'(b0_reg),  SUM_WIDTH'(b1_reg), SUM_WIDTH'(b2_reg))
             + K_CORNER * tri_sum(SUM_WIDTH'(c0_reg),  SUM_WIDTH'(c1_reg), SUM_WIDTH'(c2_reg));

`ifdef GAUSSIAN_ROUND_EN
  assign sum_adj = sum + ROUND_CONST;
`else
  assign sum_adj = sum;
`endif

  assign filt = DWIDTH'(sum_adj >> SUM_SHIFT);

  assign out_border    = (out_row_reg == '0) || (out_row_reg == ROW_LAST) ||
                         (out_col_reg == '0) || (out_col_reg == COL_LAST);
  assign last_in       = (in_row_reg == ROW_LAST) && (in_col_reg == COL_LAST);
  assign last_out      = (out_row_reg == ROW_LAST) && (out_col_reg == COL_LAST);
  assign prologue_done = (in_row_reg == RW'(1)) && (in_col_reg == '0);

  // go_reg holds the handshakes off for the first cycle after reset release.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= PROLOGUE;
      go_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      go_reg    <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    if (!reset && go_reg) begin
      case (state_reg)
        PROLOGUE: begin
          in_rd_en = ~in_empty;
          if (in_rd_en && prologue_done) state_next = RUN;
        end
        RUN: begin
          in_rd_en  = ~in_empty & ~out_full;
          out_wr_en = in_rd_en;
          out_din   = out_border ? '0 : filt;
          if (in_rd_en && last_in) state_next = FLUSH;
        end
        FLUSH: begin
          out_wr_en = ~out_full;
          if (out_wr_en && last_out) state_next = PROLOGUE;
        end
        default: state_next = PROLOGUE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_col_reg  <= '0;
      in_row_reg  <= '0;
      out_col_reg <= '0;
      out_row_reg <= '0;
    end else begin
      if (in_rd_en) begin
        if (in_col_reg == COL_LAST) begin
          in_col_reg <= '0;
          in_row_reg <= (in_row_reg == ROW_LAST) ? '0 : in_row_reg + 1'b1;
        end else begin
          in_col_reg <= in_col_reg + 1'b1;
        end
      end
      if (out_wr_en) begin
        if (out_col_reg == COL_LAST) begin
          out_col_reg <= '0;
          out_row_reg <= (out_row_reg == ROW_LAST) ? '0 : out_row_reg + 1'b1;
        end else begin
          out_col_reg <= out_col_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gaussian_filter.sv
// Scoreboard bench for gaussian_filter on 64x32 frames: FIFO-model driver, queue-based monitor.
module tb_gaussian_filter;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int DW = 8;

`ifdef GAUSSIAN_ROUND_EN
  localparam int IMP_C = 64, IMP_E = 32, IMP_D = 16;
`else
  localparam int IMP_C = 63, IMP_E = 31, IMP_D = 15;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_dout = '0;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] out_din;
  logic          out_full = 1'b0;
  logic          out_wr_en;

  gaussian_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_dout   (in_dout),
    .in_empty  (in_empty),
    .in_rd_en  (in_rd_en),
    .out_din   (out_din),
    .out_full  (out_full),
    .out_wr_en (out_wr_en)
  );

  always #5 clock = ~clock;

  logic [7:0] img     [H][W];
  logic [7:0] out_img [H][W];
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int wr_total   = 0;
  int frame_base = 0;
  bit stall_mode = 0;
  int burst      = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Direct 2-D convolution of the stored image.
  function automatic int golden(input int r, input int c);
    int s;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(img[r+dr][c+dc]);
`ifdef GAUSSIAN_ROUND_EN
    return (s + 8) >> 4;
`else
    return s >> 4;
`endif
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (mode)
          0:       img[r][c] = 8'd100;
          1:       img[r][c] = (r == 5 && c == 5) ? 8'd255 : 8'd0;
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // Expectations for the whole frame are queued before any pixel is offered.
  task automatic load_frame(input int n_pix);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back(8'(golden(r, c)));
    for (int i = 0; i < n_pix; i++)
      src_q.push_back(img[i / W][i % W]);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (k >= budget) check({tag, "_timeout_pending"}, exp_q.size(), 0);
    repeat (4) @(negedge clock);
  endtask

  // Upstream FWFT FIFO and downstream full flag model.
  initial begin
    logic [7:0] dummy;
    forever begin
      @(negedge clock);
      if (stall_mode) begin
        out_full = ($urandom_range(0, 3) == 0);
        if (burst > 0) burst--;
        else if ($urandom_range(0, 15) == 0) burst = $urandom_range(1, 8);
      end else begin
        out_full = 1'b0;
        burst    = 0;
      end
      in_empty = (src_q.size() == 0) || (burst > 0);
      in_dout  = (src_q.size() != 0) ? src_q[0] : '0;
      #1;
      if (in_rd_en && src_q.size() != 0) dummy = src_q.pop_front();
    end
  end

  // Monitor: protocol checks and scoreboard compare on every write.
  initial begin
    logic [7:0] e;
    int pos, r, c;
    forever begin
      @(negedge clock);
      #2;
      if (in_rd_en) check("rd_while_empty", int'(in_empty), 0);
      if (out_wr_en) begin
        check("wr_while_full", int'(out_full), 0);
        pos = wr_total - frame_base;
        r = (pos / W) % H;
        c = pos % W;
        if (exp_q.size() == 0) begin
          check("write_with_empty_scoreboard", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          out_img[r][c] = out_din;
          check($sformatf("pix_r%0d_c%0d", r, c), int'(out_din), int'(e));
        end
        wr_total++;
      end
    end
  end

  initial begin
    int k;
    // Reset behaviour, with data already waiting upstream.
    reset = 1'b1;
    fill(0);
    load_frame(W * H);
    repeat (3) @(negedge clock);
    #3;
    check("rd_en_in_reset", int'(in_rd_en), 0);
    check("wr_en_in_reset", int'(out_wr_en), 0);
    @(negedge clock);
    reset = 1'b0;
    #3;
    check("rd_en_after_reset", int'(in_rd_en), 0);
    check("wr_en_after_reset", int'(out_wr_en), 0);

    // Uniform 100 frame.
    wait_idle("uniform", 20000);
    check("uniform_writes", wr_total - frame_base, W * H);
    check("uniform_interior", int'(out_img[10][10]), 100);
    check("uniform_border_row0", int'(out_img[0][3]), 0);
    check("uniform_border_colL", int'(out_img[7][W-1]), 0);
    $display("frame uniform: %0d writes", wr_total - frame_base);

    // Single 255 impulse at (5,5).
    frame_base = wr_total;
    fill(1);
    load_frame(W * H);
    wait_idle("impulse", 20000);
    check("impulse_writes", wr_total - frame_base, W * H);
    check("impulse_centre", int'(out_img[5][5]), IMP_C);
    check("impulse_n", int'(out_img[4][5]), IMP_E);
    check("impulse_s", int'(out_img[6][5]), IMP_E);
    check("impulse_w", int'(out_img[5][4]), IMP_E);
    check("impulse_e", int'(out_img[5][6]), IMP_E);
    check("impulse_nw", int'(out_img[4][4]), IMP_D);
    check("impulse_ne", int'(out_img[4][6]), IMP_D);
    check("impulse_sw", int'(out_img[6][4]), IMP_D);
    check("impulse_se", int'(out_img[6][6]), IMP_D);
    check("impulse_far", int'(out_img[5][7]), 0);
    $display("frame impulse: %0d writes", wr_total - frame_base);

    // Random frame under downstream full toggling and upstream empty bursts.
    frame_base = wr_total;
    stall_mode = 1;
    fill(2);
    load_frame(W * H);
    wait_idle("stalled", 40000);
    stall_mode = 0;
    check("stalled_writes", wr_total - frame_base, W * H);
    $display("frame random_stalled: %0d writes", wr_total - frame_base);

    // Abandon a frame after 1000 accepted pixels.
    frame_base = wr_total;
    fill(2);
    load_frame(1000);
    k = 0;
    while (src_q.size() != 0 && k < 5000) begin
      @(negedge clock);
      k++;
    end
    repeat (4) @(negedge clock);
    check("partial_src_drained", src_q.size(), 0);
    check("partial_writes", wr_total - frame_base, 1000 - (W + 1));
    check("partial_pending", exp_q.size(), W * H - (1000 - (W + 1)));
    reset = 1'b1;
    repeat (2) @(negedge clock);
    exp_q.delete();
    reset = 1'b0;
    frame_base = wr_total;
    fill(2);
    load_frame(W * H);
    wait_idle("after_reset", 20000);
    check("after_reset_writes", wr_total - frame_base, W * H);
    $display("frame after_reset: %0d writes", wr_total - frame_base);

    // Two frames back to back.
    frame_base = wr_total;
    fill(2);
    load_frame(W * H);
    fill(2);
    load_frame(W * H);
    wait_idle("back_to_back", 30000);
    check("b2b_writes", wr_total - frame_base, 2 * W * H);
    $display("frames back_to_back: %0d writes", wr_total - frame_base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
